// File: rtl/core_pkg.sv
// Shared core definitions: datapath defaults, the x0 register address and
// the load-use hazard controller state type.
package core_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned RA_W_DEF = 5;
   localparam logic [31:0] REG_ZERO = '0;

   typedef enum logic {RUN, LDWAIT} hz_state_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-source EX operand selection: l3 result, then held l4 value, then live l4
// result, then register-file read. x0 never matches.
module fwd_src_sel
   import core_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] rs,
   input  logic [XLEN-1:0] xrs,
   input  logic [RA_W-1:0] rd_l3,
   input  logic            wen_l3,
   input  logic [XLEN-1:0] wval_l3,
   input  logic [RA_W-1:0] rd_l4,
   input  logic            wen_l4,
   input  logic [XLEN-1:0] wval_l4,
   input  logic            hold_v,
   input  logic [XLEN-1:0] hold,
   output logic [XLEN-1:0] operand,
   output logic            m3,
   output logic            m4
);

   assign m3 = wen_l3 && (rd_l3 != REG_ZERO[RA_W-1:0]) && (rd_l3 == rs);
   assign m4 = wen_l4 && (rd_l4 != REG_ZERO[RA_W-1:0]) && (rd_l4 == rs);

   always_comb begin
      operand = xrs;
      if (m3)
         operand = wval_l3;
      else if (hold_v)
         operand = hold;
      else if (m4)
         operand = wval_l4;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding with l3/l4 priority and load-use stall control against a
// variable-latency data memory; keeps l4 values captured across the stall.
module fwd_hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned RA_W     = RA_W_DEF,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_l2,
   input  logic [RA_W-1:0]  rs1_l2,
   input  logic [RA_W-1:0]  rs2_l2,
   input  logic [XLEN-1:0]  xrs1_l2,
   input  logic [XLEN-1:0]  xrs2_l2,
   input  logic [RA_W-1:0]  rd_l3,
   input  logic             wen_l3,
   input  logic             is_load_l3,
   input  logic             ld_valid_l3,
   input  logic [XLEN-1:0]  wval_l3,
   input  logic [RA_W-1:0]  rd_l4,
   input  logic             wen_l4,
   input  logic [XLEN-1:0]  wval_l4,
   output logic [XLEN-1:0]  alu_a_l2,
   output logic [XLEN-1:0]  alu_b_l2,
   output logic             stall_l2,
   output logic             bubble_l4,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err_timeout
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   hz_state_e       state, state_nxt;
   logic            m31, m32, m41, m42;
   logic            hold_v1, hold_v2;
   logic [XLEN-1:0] hold_1, hold_2;
   logic            hz, capture, release_hold;
   logic [WW-1:0]   wait_cnt, wait_inc;

   fwd_src_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_src1 (
      .rs(rs1_l2), .xrs(xrs1_l2),
      .rd_l3(rd_l3), .wen_l3(wen_l3), .wval_l3(wval_l3),
      .rd_l4(rd_l4), .wen_l4(wen_l4), .wval_l4(wval_l4),
      .hold_v(hold_v1), .hold(hold_1),
      .operand(alu_a_l2), .m3(m31), .m4(m41)
   );

   fwd_src_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_src2 (
      .rs(rs2_l2), .xrs(xrs2_l2),
      .rd_l3(rd_l3), .wen_l3(wen_l3), .wval_l3(wval_l3),
      .rd_l4(rd_l4), .wen_l4(wen_l4), .wval_l4(wval_l4),
      .hold_v(hold_v2), .hold(hold_2),
      .operand(alu_b_l2), .m3(m32), .m4(m42)
   );

   assign hz        = is_load_l3 && (m31 || m32) && !ld_valid_l3 && !flush_l2;
   assign stall_l2  = hz;
   assign bubble_l4 = hz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // Any LDWAIT cycle without a hazard (data valid, flush, or match gone) releases the stall.
   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      release_hold = 1'b0;
      if (flush_l2) begin
         state_nxt    = RUN;
         release_hold = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (hz) begin
                  state_nxt = LDWAIT;
                  capture   = 1'b1;
               end
            end
            LDWAIT: begin
               if (!hz) begin
                  state_nxt    = RUN;
                  release_hold = 1'b1;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v1 <= 1'b0;
         hold_v2 <= 1'b0;
         hold_1  <= '0;
         hold_2  <= '0;
      end else if (capture) begin
         hold_1  <= wval_l4;
         hold_2  <= wval_l4;
         hold_v1 <= m41 && !m31;
         hold_v2 <= m42 && !m32;
      end else if (release_hold) begin
         hold_v1 <= 1'b0;
         hold_v2 <= 1'b0;
      end
   end

   assign wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else if (capture) begin
         wait_cnt <= '0;
      end else if (state == LDWAIT && hz) begin
         wait_cnt <= wait_inc;
         if (wait_inc == WAIT_MAX)
            err_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (hz && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: table vectors, directed stall sequences and a
// randomized run against a cycle-level reference model.
module tb_fwd_hazard_ctrl;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned RA_W     = 5;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned MAX_WAIT = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush_l2;
   logic [RA_W-1:0]  rs1_l2, rs2_l2, rd_l3, rd_l4;
   logic [XLEN-1:0]  xrs1_l2, xrs2_l2, wval_l3, wval_l4;
   logic             wen_l3, is_load_l3, ld_valid_l3, wen_l4;
   logic [XLEN-1:0]  alu_a_l2, alu_b_l2;
   logic             stall_l2, bubble_l4, err_timeout;
   logic [CNT_W-1:0] stall_cnt;

   fwd_hazard_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .flush_l2(flush_l2),
      .rs1_l2(rs1_l2), .rs2_l2(rs2_l2), .xrs1_l2(xrs1_l2), .xrs2_l2(xrs2_l2),
      .rd_l3(rd_l3), .wen_l3(wen_l3), .is_load_l3(is_load_l3),
      .ld_valid_l3(ld_valid_l3), .wval_l3(wval_l3),
      .rd_l4(rd_l4), .wen_l4(wen_l4), .wval_l4(wval_l4),
      .alu_a_l2(alu_a_l2), .alu_b_l2(alu_b_l2), .stall_l2(stall_l2),
      .bubble_l4(bubble_l4), .stall_cnt(stall_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic [4:0]  rs1, rs2;
      logic [31:0] xrs1, xrs2;
      logic [4:0]  rd3;
      logic        wen3, ld3, ldv3;
      logic [31:0] wval3;
      logic [4:0]  rd4;
      logic        wen4;
      logic [31:0] wval4;
      logic [31:0] exp_a, exp_b;
      logic        exp_stall;
   } vec_t;

   vec_t vecs[8];

   // reference model state: pending load wait, captured l4 values, timers
   bit          m_wait;
   bit          m_hv[2];
   logic [31:0] m_h[2];
   int          m_wcnt;
   bit          m_err;
   int          m_stalls;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      flush_l2 = 0; rs1_l2 = 0; rs2_l2 = 0; xrs1_l2 = 0; xrs2_l2 = 0;
      rd_l3 = 0; wen_l3 = 0; is_load_l3 = 0; ld_valid_l3 = 0; wval_l3 = 0;
      rd_l4 = 0; wen_l4 = 0; wval_l4 = 0;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      m_wait = 0; m_hv[0] = 0; m_hv[1] = 0; m_h[0] = 0; m_h[1] = 0;
      m_wcnt = 0; m_err = 0; m_stalls = 0;
   endtask

   task automatic load_use(input logic [4:0] rd);
      is_load_l3 = 1; wen_l3 = 1; rd_l3 = rd; rs1_l2 = rd; ld_valid_l3 = 0;
      wval_l3 = 32'hDEAD;
   endtask

   function automatic logic [31:0] pick(input logic [4:0] rs, input logic [31:0] xrs,
                                        input bit hv, input logic [31:0] h);
      if (wen_l3 && rd_l3 != 0 && rd_l3 == rs) return wval_l3;
      if (hv) return h;
      if (wen_l4 && rd_l4 != 0 && rd_l4 == rs) return wval_l4;
      return xrs;
   endfunction

   initial begin
      vecs[0] = '{5'd5, 5'd1, 32'hA1, 32'hB1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h11, 5'd5, 1'b1, 32'h22, 32'h11, 32'hB1, 1'b0};
      vecs[1] = '{5'd5, 5'd1, 32'hA1, 32'hB1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h11, 5'd5, 1'b1, 32'h22, 32'h22, 32'hB1, 1'b0};
      vecs[2] = '{5'd3, 5'd0, 32'hA1, 32'hB2, 5'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF, 5'd0, 1'b1, 32'h22, 32'hA1, 32'hB2, 1'b0};
      vecs[3] = '{5'd6, 5'd6, 32'hA3, 32'hB3, 5'd2, 1'b1, 1'b0, 1'b0, 32'h77, 5'd6, 1'b1, 32'h66, 32'h66, 32'h66, 1'b0};
      vecs[4] = '{5'd4, 5'd2, 32'hA4, 32'hB4, 5'd4, 1'b1, 1'b1, 1'b1, 32'hCAFE, 5'd0, 1'b0, 32'h0, 32'hCAFE, 32'hB4, 1'b0};
      vecs[5] = '{5'd1, 5'd2, 32'hA5, 32'hB5, 5'd4, 1'b1, 1'b1, 1'b0, 32'h55, 5'd0, 1'b0, 32'h0, 32'hA5, 32'hB5, 1'b0};
      vecs[6] = '{5'd0, 5'd2, 32'hA6, 32'hB6, 5'd0, 1'b1, 1'b1, 1'b0, 32'h66, 5'd0, 1'b0, 32'h0, 32'hA6, 32'hB6, 1'b0};
      vecs[7] = '{5'd8, 5'd9, 32'hA7, 32'hB7, 5'd9, 1'b1, 1'b0, 1'b0, 32'h33, 5'd8, 1'b1, 32'h44, 32'h44, 32'h33, 1'b0};

      do_reset();
      settle();
      chk("reset_stall_cnt", 32'(stall_cnt), 0);
      chk("reset_err", 32'(err_timeout), 0);
      chk("reset_stall", 32'(stall_l2), 0);
      tick();

      foreach (vecs[i]) begin
         rs1_l2 = vecs[i].rs1; rs2_l2 = vecs[i].rs2;
         xrs1_l2 = vecs[i].xrs1; xrs2_l2 = vecs[i].xrs2;
         rd_l3 = vecs[i].rd3; wen_l3 = vecs[i].wen3; is_load_l3 = vecs[i].ld3;
         ld_valid_l3 = vecs[i].ldv3; wval_l3 = vecs[i].wval3;
         rd_l4 = vecs[i].rd4; wen_l4 = vecs[i].wen4; wval_l4 = vecs[i].wval4;
         settle();
         chk($sformatf("vec%0d_a", i), alu_a_l2, vecs[i].exp_a);
         chk($sformatf("vec%0d_b", i), alu_b_l2, vecs[i].exp_b);
         chk($sformatf("vec%0d_stall", i), 32'(stall_l2), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_bubble", i), 32'(bubble_l4), 32'(vecs[i].exp_stall));
         tick();
      end
      settle();
      chk("table_stall_cnt", 32'(stall_cnt), 0);

      // load-use against a 3-cycle memory
      do_reset();
      load_use(5'd7);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk($sformatf("lu_stall%0d", i), 32'(stall_l2), 1);
         chk($sformatf("lu_bubble%0d", i), 32'(bubble_l4), 1);
         tick();
      end
      ld_valid_l3 = 1; wval_l3 = 32'hCAFE;
      settle();
      chk("lu_data", alu_a_l2, 32'hCAFE);
      chk("lu_release", 32'(stall_l2), 0);
      chk("lu_stall_cnt", 32'(stall_cnt), 3);
      tick();

      // l4 value captured at stall entry survives the bubbles
      do_reset();
      load_use(5'd7);
      rs2_l2 = 9; xrs2_l2 = 32'hBAD; rd_l4 = 9; wen_l4 = 1; wval_l4 = 32'h1234;
      settle();
      chk("hold_entry", alu_b_l2, 32'h1234);
      tick();
      wen_l4 = 0; wval_l4 = 32'h5555;
      settle();
      chk("hold_wait", alu_b_l2, 32'h1234);
      chk("hold_wait_stall", 32'(stall_l2), 1);
      tick();
      ld_valid_l3 = 1; wval_l3 = 32'hCAFE;
      settle();
      chk("hold_release", alu_b_l2, 32'h1234);
      tick();
      is_load_l3 = 0; wen_l3 = 0; ld_valid_l3 = 0;
      settle();
      chk("hold_after", alu_b_l2, 32'hBAD);
      tick();

      // flush mid-stall
      do_reset();
      load_use(5'd7);
      rs2_l2 = 9; xrs2_l2 = 32'hBAD; rd_l4 = 9; wen_l4 = 1; wval_l4 = 32'h1234;
      tick();
      wen_l4 = 0;
      settle();
      chk("fl_wait", 32'(stall_l2), 1);
      tick();
      flush_l2 = 1;
      settle();
      chk("fl_stall", 32'(stall_l2), 0);
      tick();
      flush_l2 = 0; is_load_l3 = 0;
      settle();
      chk("fl_hold_clr", alu_b_l2, 32'hBAD);
      tick();
      // a fresh hazard must capture again, which only happens from RUN
      is_load_l3 = 1; wen_l4 = 1; wval_l4 = 32'h7777;
      tick();
      wen_l4 = 0;
      settle();
      chk("fl_recapture", alu_b_l2, 32'h7777);
      tick();

      // timeout, stickiness, asynchronous reset
      do_reset();
      load_use(5'd7);
      tick();
      for (int i = 0; i < MAX_WAIT; i++) begin
         settle();
         chk($sformatf("to_pre%0d", i), 32'(err_timeout), 0);
         tick();
      end
      ld_valid_l3 = 1;
      settle();
      chk("to_set", 32'(err_timeout), 1);
      chk("to_stall_cnt", 32'(stall_cnt), MAX_WAIT + 1);
      tick();
      idle();
      tick();
      settle();
      chk("to_sticky", 32'(err_timeout), 1);
      load_use(5'd7);
      #1 rst_n = 0;
      #1;
      chk("arst_err", 32'(err_timeout), 0);
      chk("arst_cnt", 32'(stall_cnt), 0);
      chk("arst_comb", 32'(stall_l2), 1);
      tick();

      // randomized run against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bit hz, m31, m32, m41, m42;
         if (!(m_wait && $urandom_range(0, 3) != 0)) begin
            rs1_l2 = 5'($urandom_range(0, 3)); rs2_l2 = 5'($urandom_range(0, 3));
            xrs1_l2 = $urandom; xrs2_l2 = $urandom;
            rd_l3 = 5'($urandom_range(0, 3)); wen_l3 = ($urandom_range(0, 3) != 0);
            is_load_l3 = $urandom_range(0, 1) == 1; wval_l3 = $urandom;
         end
         ld_valid_l3 = ($urandom_range(0, 4) == 0);
         flush_l2 = ($urandom_range(0, 15) == 0);
         rd_l4 = 5'($urandom_range(0, 3)); wen_l4 = ($urandom_range(0, 3) != 0);
         wval_l4 = $urandom;
         settle();
         m31 = wen_l3 && rd_l3 != 0 && rd_l3 == rs1_l2;
         m32 = wen_l3 && rd_l3 != 0 && rd_l3 == rs2_l2;
         m41 = wen_l4 && rd_l4 != 0 && rd_l4 == rs1_l2;
         m42 = wen_l4 && rd_l4 != 0 && rd_l4 == rs2_l2;
         hz = is_load_l3 && (m31 || m32) && !ld_valid_l3 && !flush_l2;
         chk("rnd_a", alu_a_l2, pick(rs1_l2, xrs1_l2, m_hv[0], m_h[0]));
         chk("rnd_b", alu_b_l2, pick(rs2_l2, xrs2_l2, m_hv[1], m_h[1]));
         chk("rnd_stall", 32'(stall_l2), 32'(hz));
         chk("rnd_bubble", 32'(bubble_l4), 32'(hz));
         chk("rnd_stall_cnt", 32'(stall_cnt), m_stalls);
         chk("rnd_err", 32'(err_timeout), 32'(m_err));
         if (flush_l2) begin
            m_wait = 0; m_hv[0] = 0; m_hv[1] = 0;
         end else if (!m_wait) begin
            if (hz) begin
               m_wait = 1; m_wcnt = 0;
               m_h[0] = wval_l4; m_h[1] = wval_l4;
               m_hv[0] = m41 && !m31; m_hv[1] = m42 && !m32;
            end
         end else if (hz) begin
            if (m_wcnt < MAX_WAIT) m_wcnt++;
            if (m_wcnt == MAX_WAIT) m_err = 1;
         end else begin
            m_wait = 0; m_hv[0] = 0; m_hv[1] = 0;
         end
         if (hz && m_stalls < 65535) m_stalls++;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
